rca8_shared_sched: RTL and testbench
====================================

RCA8_SHARED_SCHED -- requirements
Module: rca8_shared_sched

Interface
- REQ-001: Parameter NREQ, default 4, number of requesters sharing the adder; the ID field is 2 bits wide, so NREQ SHALL be 2..4.
- REQ-002: Parameter W, default 8, adder operand width; fixed at 8.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: req_valid  input  NREQ  per-requester beat valid.
- REQ-006: req_ready  output  NREQ  per-requester beat accept.
- REQ-007: req_a  input  NREQ*W  operand A; requester i owns bits [i*W +: W].
- REQ-008: req_b  input  NREQ*W  operand B, same packing as req_a.
- REQ-009: req_last  input  NREQ  beat is the final (most significant) byte of its operation.
- REQ-010: res_valid  output  1  result register holds a beat.
- REQ-011: res_ready  input  1  downstream accepts the result.
- REQ-012: res_sum  output  W  sum byte.
- REQ-013: res_cout  output  1  carry-out of that byte.
- REQ-014: res_last  output  1  copy of the accepted beat's req_last.
- REQ-015: res_id  output  2  index of the requester that produced the beat.
- REQ-016: busy  output  1  high when state is BURST or res_valid=1.

Function
- REQ-017: One internal W-bit ripple-carry adder SHALL compute {cout,sum} = a + b + cin for the granted requester's operands.
- REQ-018: FSM states SHALL be IDLE and BURST.
- REQ-019: In IDLE, grant g SHALL go to the first requester with req_valid=1, searching round-robin from (ptr+1) mod NREQ, where ptr is the last requester that completed a last beat.
- REQ-020: In BURST, g SHALL be the locked requester, regardless of other valids.
- REQ-021: req_ready[g] SHALL be high iff a grant exists and (res_valid=0 or res_ready=1); all other req_ready bits SHALL be 0.
- REQ-022: A beat is accepted when req_valid[g] and req_ready[g] are both high; cin SHALL be 0 on the first beat of an operation and the stored carry on later beats.
- REQ-023: On acceptance, res_sum, res_cout, res_last and res_id SHALL load on the next edge with res_valid=1; latency is 1 cycle.
- REQ-024: Accepted beat with last=0: state goes to BURST, g is locked, and the carry register loads cout.
- REQ-025: Accepted beat with last=1: state goes to IDLE, ptr loads g, and the carry register clears.
- REQ-026: A result held with res_ready=0 SHALL keep all res_* outputs stable; res_valid SHALL clear only on transfer with no new acceptance.
- REQ-027: A transfer and a new acceptance in the same cycle SHALL be back-to-back, giving throughput of 1 beat per cycle.
- REQ-028: If the locked requester drops req_valid mid-burst, the block SHALL stay in BURST indefinitely with no other grant (no timeout).
- REQ-029: Requesters SHALL hold req_valid and their operands stable until accepted; the block SHALL NOT check this.

Reset
- REQ-030: While rst=1, the block SHALL set state=IDLE, ptr=NREQ-1 (requester 0 first), carry=0, res_valid=0, res_sum=0, res_cout=0, res_last=0, res_id=0, req_ready=0 and busy=0.
- REQ-031: rst asserted mid-burst SHALL abandon the operation and drop any pending result; the first grant after release SHALL be requester 0 if it is valid.

Verification
- REQ-032: Single beat: req0 a=0xFF, b=0x01, last=1, res_ready=1 -> next cycle res_valid=1, res_sum=0x00, res_cout=1, res_id=0, res_last=1.
- REQ-033: Carry chain: req2 sends beat (0xFF,0x01,last=0) then (0x00,0x00,last=1) -> results (0x00,c=1,last=0) then (0x01,c=0,last=1), i.e. 0x00FF+0x0001=0x0100.
- REQ-034: Round robin: all four requesters continuously valid with single beats, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles.
- REQ-035: Lock: req1 3-beat burst while req0 and req3 are valid -> req_ready[0] and req_ready[3] stay 0 until req1's last beat is accepted, and the next grant is 3.
- REQ-036: Backpressure: res_ready=0 for 3 cycles with a result held -> res_* stable and req_ready=0; on res_ready=1 the transfer and the next acceptance occur in the same cycle.
- REQ-037: Reset mid-burst: rst pulse after beat 1 of a 2-beat req2 operation -> res_valid=0 and busy=0; the next operation's first beat uses cin=0.

Source files
------------

// File: rtl/rca8_shared_sched.sv
// Shared 8-bit ripple-carry adder time-multiplexed between NREQ requesters.
// Multi-byte operations arrive LSB-first as bursts; the carry is chained between beats.
module rca8_shared_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [W-1:0]      res_sum_o,
  output logic              res_cout_o,
  output logic              res_last_o,
  output logic [1:0]        res_id_o,
  output logic              busy_o
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t       state_q;
  logic [1:0]   lock_q;
  logic [1:0]   ptr_q;
  logic         carry_q;
  logic         resValid_q;
  logic [W-1:0] resSum_q;
  logic         resCout_q;
  logic         resLast_q;
  logic [1:0]   resId_q;

  logic         grantFound;
  logic [1:0]   grantIdx;
  logic [1:0]   cand;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         selValid;
  logic         selLast;
  logic         canLoad;
  logic         accept;
  logic         cin;
  logic [W:0]   chain;
  logic [W-1:0] sum_d;
  logic         cout_d;

  // A locked burst owns the adder; otherwise search round-robin after the last finisher.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = lock_q;
    cand       = '0;
    if (state_q == BURST) begin
      grantFound = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = 2'((int'(ptr_q) + k) % NREQ);
        if (!grantFound && req_valid_i[cand]) begin
          grantFound = 1'b1;
          grantIdx   = cand;
        end
      end
    end
  end

  always_comb begin
    opA      = '0;
    opB      = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == 2'(i)) begin
        opA      = req_a_i[i*W +: W];
        opB      = req_b_i[i*W +: W];
        selValid = req_valid_i[i];
        selLast  = req_last_i[i];
      end
    end
  end

  assign canLoad = !resValid_q || res_ready_i;
  assign accept  = grantFound && canLoad && selValid;
  assign cin     = (state_q == BURST) ? carry_q : 1'b0;

  assign chain[0] = cin;
  for (genvar j = 0; j < W; j++) begin : g_rca
    assign sum_d[j]   = opA[j] ^ opB[j] ^ chain[j];
    assign chain[j+1] = (opA[j] & opB[j]) | (chain[j] & (opA[j] ^ opB[j]));
  end
  assign cout_d = chain[W];

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = !rst_i && grantFound && canLoad && (grantIdx == 2'(i));
    end
  end

  // Result register doubles as a one-deep skid: a transfer and a new load may share a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_q     <= '0;
      ptr_q      <= 2'(NREQ - 1);
      carry_q    <= 1'b0;
      resValid_q <= 1'b0;
      resSum_q   <= '0;
      resCout_q  <= 1'b0;
      resLast_q  <= 1'b0;
      resId_q    <= '0;
    end else begin
      if (accept) begin
        resValid_q <= 1'b1;
        resSum_q   <= sum_d;
        resCout_q  <= cout_d;
        resLast_q  <= selLast;
        resId_q    <= grantIdx;
        if (selLast) begin
          state_q <= IDLE;
          ptr_q   <= grantIdx;
          carry_q <= 1'b0;
        end else begin
          state_q <= BURST;
          lock_q  <= grantIdx;
          carry_q <= cout_d;
        end
      end else if (res_ready_i) begin
        resValid_q <= 1'b0;
      end
    end
  end

  assign res_valid_o = resValid_q && !rst_i;
  assign res_sum_o   = resSum_q;
  assign res_cout_o  = resCout_q;
  assign res_last_o  = resLast_q;
  assign res_id_o    = resId_q;
  assign busy_o      = !rst_i && ((state_q == BURST) || resValid_q);

endmodule

// File: tb/tb_rca8_shared_sched.sv
// Bench for rca8_shared_sched: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against an arithmetic scheduling model.
module tb_rca8_shared_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*W-1:0] req_a_i;
  logic [NREQ*W-1:0] req_b_i;
  logic [NREQ-1:0]   req_last_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [W-1:0]      res_sum_o;
  logic              res_cout_o;
  logic              res_last_o;
  logic [1:0]        res_id_o;
  logic              busy_o;

  int compared   = 0;
  int mismatched = 0;

  // Model state: who owns the adder, whose turn is next, pending carry, held result.
  bit mBurst    = 1'b0;
  int mLock     = 0;
  int mPtr      = NREQ - 1;
  int mCarry    = 0;
  bit mResValid = 1'b0;
  int mResSum   = 0;
  bit mResCout  = 1'b0;
  bit mResLast  = 1'b0;
  int mResId    = 0;
  int mAccepted = -1;

  always #5 clk_i = ~clk_i;

  rca8_shared_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_last_i(req_last_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_sum_o(res_sum_o), .res_cout_o(res_cout_o), .res_last_o(res_last_o),
    .res_id_o(res_id_o), .busy_o(busy_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin : compare
    int        g;
    bit        found;
    bit        canLoad;
    logic [3:0] expReady;
    int        a;
    int        b;
    int        t;
    found = 1'b0;
    g     = 0;
    if (mBurst) begin
      found = 1'b1;
      g     = mLock;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req_valid_i[(mPtr + k) % NREQ]) begin
          found = 1'b1;
          g     = (mPtr + k) % NREQ;
        end
      end
    end
    canLoad  = !mResValid || res_ready_i;
    expReady = (found && canLoad && !rst_i) ? 4'(1 << g) : 4'b0000;
    checkOutput("req_ready", 32'(req_ready_o), 32'(expReady));
    checkOutput("res_valid", 32'(res_valid_o), 32'(mResValid && !rst_i));
    checkOutput("busy", 32'(busy_o), 32'((mBurst || mResValid) && !rst_i));
    checkOutput("res_sum", 32'(res_sum_o), mResSum);
    checkOutput("res_cout", 32'(res_cout_o), 32'(mResCout));
    checkOutput("res_last", 32'(res_last_o), 32'(mResLast));
    checkOutput("res_id", 32'(res_id_o), mResId);

    mAccepted = -1;
    if (rst_i) begin
      mBurst = 0; mLock = 0; mPtr = NREQ - 1; mCarry = 0;
      mResValid = 0; mResSum = 0; mResCout = 0; mResLast = 0; mResId = 0;
    end else if (found && canLoad && req_valid_i[g]) begin
      a = int'(req_a_i[g*W +: W]);
      b = int'(req_b_i[g*W +: W]);
      t = a + b + (mBurst ? mCarry : 0);
      mAccepted = g;
      mResValid = 1;
      mResSum   = t % 256;
      mResCout  = (t >= 256);
      mResLast  = req_last_i[g];
      mResId    = g;
      if (req_last_i[g]) begin
        mBurst = 0; mPtr = g; mCarry = 0;
      end else begin
        mBurst = 1; mLock = g; mCarry = t / 256;
      end
    end else if (res_ready_i) begin
      mResValid = 0;
    end
  end

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setReq(input int i, input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit last);
    req_valid_i[i]     = v;
    req_a_i[i*W +: W]  = a;
    req_b_i[i*W +: W]  = b;
    req_last_i[i]      = last;
  endtask

  task automatic clearReqs();
    req_valid_i = '0;
    req_last_i  = '0;
  endtask

  // Random traffic; a pending beat is held until the model sees it accepted.
  task automatic applyStimulus();
    bit wasReset;
    wasReset    = rst_i;
    rst_i       = ($urandom_range(0, 199) == 0);
    res_ready_i = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NREQ; i++) begin
      if (!(req_valid_i[i] && mAccepted != i && !wasReset)) begin
        setReq(i, $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
               $urandom_range(0, 2) == 0);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; res_ready_i = 1'b1;
    req_valid_i = '0; req_last_i = '0; req_a_i = '0; req_b_i = '0;
    nextCycle();
    nextCycle();
    @(negedge clk_i);
    checkOutput("rst_res_valid", 32'(res_valid_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_req_ready", 32'(req_ready_o), 0);
    checkOutput("rst_res_sum", 32'(res_sum_o), 0);
    checkOutput("rst_res_id", 32'(res_id_o), 0);

    // Single beat 0xFF + 0x01
    nextCycle(); rst_i = 1'b0; setReq(0, 1, 8'hFF, 8'h01, 1);
    @(negedge clk_i); checkOutput("t1_ready", 32'(req_ready_o), 32'h1);
    nextCycle(); clearReqs();
    @(negedge clk_i);
    checkOutput("t1_valid", 32'(res_valid_o), 1);
    checkOutput("t1_sum", 32'(res_sum_o), 32'h00);
    checkOutput("t1_cout", 32'(res_cout_o), 1);
    checkOutput("t1_id", 32'(res_id_o), 0);
    checkOutput("t1_last", 32'(res_last_o), 1);

    // 0x00FF + 0x0001 over two beats on requester 2
    nextCycle(); setReq(2, 1, 8'hFF, 8'h01, 0);
    nextCycle(); setReq(2, 1, 8'h00, 8'h00, 1);
    @(negedge clk_i);
    checkOutput("cc_sum0", 32'(res_sum_o), 32'h00);
    checkOutput("cc_cout0", 32'(res_cout_o), 1);
    checkOutput("cc_last0", 32'(res_last_o), 0);
    checkOutput("cc_busy", 32'(busy_o), 1);
    nextCycle(); clearReqs();
    @(negedge clk_i);
    checkOutput("cc_sum1", 32'(res_sum_o), 32'h01);
    checkOutput("cc_cout1", 32'(res_cout_o), 0);
    checkOutput("cc_id1", 32'(res_id_o), 2);

    // Round robin from a fresh reset
    nextCycle(); rst_i = 1'b1;
    nextCycle(); rst_i = 1'b0;
    for (int i = 0; i < NREQ; i++) setReq(i, 1, 8'(i * 16 + 1), 8'(i), 1);
    @(negedge clk_i); checkOutput("rr_ready", 32'(req_ready_o), 32'h1);
    for (int n = 0; n < 5; n++) begin
      nextCycle();
      if (n == 4) clearReqs();
      @(negedge clk_i); checkOutput("rr_id", 32'(res_id_o), n % 4);
    end

    // Requester 1 burst locks out 0 and 3
    nextCycle();
    setReq(0, 1, 8'h05, 8'h05, 1); setReq(3, 1, 8'h07, 8'h07, 1); setReq(1, 1, 8'h80, 8'h80, 0);
    @(negedge clk_i); checkOutput("lk_ready0", 32'(req_ready_o), 32'h2);
    nextCycle(); setReq(1, 1, 8'h00, 8'hFF, 0);
    @(negedge clk_i);
    checkOutput("lk_ready1", 32'(req_ready_o), 32'h2);
    checkOutput("lk_sum1", 32'(res_sum_o), 32'h00);
    checkOutput("lk_cout1", 32'(res_cout_o), 1);
    nextCycle(); setReq(1, 1, 8'h01, 8'h02, 1);
    @(negedge clk_i);
    checkOutput("lk_ready2", 32'(req_ready_o), 32'h2);
    checkOutput("lk_sum2", 32'(res_sum_o), 32'h00);
    nextCycle(); req_valid_i[1] = 1'b0;
    @(negedge clk_i);
    checkOutput("lk_ready3", 32'(req_ready_o), 32'h8);
    checkOutput("lk_sum3", 32'(res_sum_o), 32'h04);
    checkOutput("lk_last3", 32'(res_last_o), 1);
    nextCycle(); req_valid_i[3] = 1'b0;
    @(negedge clk_i);
    checkOutput("lk_id3", 32'(res_id_o), 3);
    checkOutput("lk_sum_r3", 32'(res_sum_o), 32'h0E);
    nextCycle(); req_valid_i[0] = 1'b0;
    @(negedge clk_i); checkOutput("lk_sum_r0", 32'(res_sum_o), 32'h0A);

    // Backpressure holds the result, then transfer and acceptance coincide
    nextCycle(); setReq(0, 1, 8'h12, 8'h34, 1);
    nextCycle(); res_ready_i = 1'b0; setReq(0, 1, 8'h20, 8'h30, 1);
    for (int n = 0; n < 3; n++) begin
      if (n > 0) nextCycle();
      @(negedge clk_i);
      checkOutput("bp_valid", 32'(res_valid_o), 1);
      checkOutput("bp_sum", 32'(res_sum_o), 32'h46);
      checkOutput("bp_ready", 32'(req_ready_o), 0);
    end
    nextCycle(); res_ready_i = 1'b1;
    @(negedge clk_i); checkOutput("bp_release", 32'(req_ready_o), 32'h1);
    nextCycle(); clearReqs();
    @(negedge clk_i); checkOutput("bp_next_sum", 32'(res_sum_o), 32'h50);
    nextCycle();
    @(negedge clk_i); checkOutput("bp_drain", 32'(res_valid_o), 0);

    // Reset mid-burst, then a fresh operation must start with carry-in 0
    nextCycle(); setReq(2, 1, 8'hFF, 8'hFF, 0);
    nextCycle(); rst_i = 1'b1; clearReqs();
    @(negedge clk_i); checkOutput("mr_busy_in_rst", 32'(busy_o), 0);
    nextCycle(); rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("mr_valid", 32'(res_valid_o), 0);
    checkOutput("mr_busy", 32'(busy_o), 0);
    nextCycle(); setReq(2, 1, 8'h01, 8'h01, 1);
    @(negedge clk_i); checkOutput("mr_ready", 32'(req_ready_o), 32'h4);
    nextCycle(); clearReqs();
    @(negedge clk_i);
    checkOutput("mr_sum", 32'(res_sum_o), 32'h02);
    checkOutput("mr_cout", 32'(res_cout_o), 0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      nextCycle();
      applyStimulus();
    end
    nextCycle(); rst_i = 1'b0; clearReqs(); res_ready_i = 1'b1;
    repeat (4) nextCycle();
    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
